// File: rtl/boot_loader.sv
`default_nettype none
// ============================================================================
//  boot_loader : framed byte-stream loader for instruction/data BRAM init ports
//  Rev 1.0
// ============================================================================
module boot_loader #(
    parameter int         ADDR_WIDTH = 15,
    parameter logic [7:0] CMD_INSTR  = 8'hA5,
    parameter logic [7:0] CMD_DATA   = 8'h5A,
    parameter logic [7:0] CMD_RUN    = 8'hC3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [ADDR_WIDTH-1:0] instr_mem_init_addr,
    output logic [31:0]           instr_mem_init_data_in,
    output logic                  instr_mem_init_enable,
    output logic [3:0]            instr_mem_init_we,
    output logic [ADDR_WIDTH-1:0] data_mem_init_addr,
    output logic [31:0]           data_mem_init_data_in,
    output logic                  data_mem_init_enable,
    output logic [3:0]            data_mem_init_we,
    output logic                  cpu_reset_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR_LO = 3'd1;
    localparam logic [2:0] S_ADDR_HI = 3'd2;
    localparam logic [2:0] S_CNT_LO  = 3'd3;
    localparam logic [2:0] S_CNT_HI  = 3'd4;
    localparam logic [2:0] S_DATA    = 3'd5;
    localparam logic [2:0] S_WRITE   = 3'd6;
    localparam logic [2:0] S_CSUM    = 3'd7;

    logic [2:0]            state_q,    state_d;
    logic                  tgt_data_q, tgt_data_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [15:0]           cnt_q,      cnt_d;
    logic [23:0]           word_q,     word_d;
    logic [1:0]            bcnt_q,     bcnt_d;
    logic [7:0]            csum_q,     csum_d;
    logic                  cpu_rst_q,  cpu_rst_d;
    logic                  err_q,      err_d;
    logic [ADDR_WIDTH-1:0] iaddr_q,    iaddr_d;
    logic [31:0]           idata_q,    idata_d;
    logic [ADDR_WIDTH-1:0] daddr_q,    daddr_d;
    logic [31:0]           ddata_q,    ddata_d;

    logic        w_accept;
    logic [31:0] w_word;
    logic [15:0] w_cnt_full;

    assign w_accept   = s_valid_i && (state_q != S_WRITE);
    // Bytes arrive LSB first, so the newest byte always lands in the top lane.
    assign w_word     = {s_data_i, word_q};
    assign w_cnt_full = {s_data_i, cnt_q[7:0]};

    always_comb begin
        state_d    = state_q;
        tgt_data_d = tgt_data_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        bcnt_d     = bcnt_q;
        csum_d     = csum_q;
        cpu_rst_d  = cpu_rst_q;
        err_d      = err_q;
        iaddr_d    = iaddr_q;
        idata_d    = idata_q;
        daddr_d    = daddr_q;
        ddata_d    = ddata_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (s_data_i == CMD_INSTR || s_data_i == CMD_DATA) begin
                        tgt_data_d = (s_data_i == CMD_DATA);
                        cpu_rst_d  = 1'b0;
                        csum_d     = 8'h00;
                        bcnt_d     = 2'd0;
                        state_d    = S_ADDR_LO;
                    end else if (s_data_i == CMD_RUN) begin
                        cpu_rst_d  = 1'b1;
                    end else begin
                        err_d      = 1'b1;
                    end
                end
            end
            S_ADDR_LO: begin
                if (w_accept) begin
                    addr_d  = ADDR_WIDTH'(s_data_i);
                    state_d = S_ADDR_HI;
                end
            end
            S_ADDR_HI: begin
                if (w_accept) begin
                    addr_d  = ADDR_WIDTH'({s_data_i, addr_q[7:0]});
                    state_d = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (w_accept) begin
                    cnt_d   = {8'h00, s_data_i};
                    state_d = S_CNT_HI;
                end
            end
            S_CNT_HI: begin
                if (w_accept) begin
                    cnt_d   = w_cnt_full;
                    bcnt_d  = 2'd0;
                    state_d = (w_cnt_full == 16'd0) ? S_CSUM : S_DATA;
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    csum_d = csum_q ^ s_data_i;
                    bcnt_d = bcnt_q + 2'd1;
                    word_d = {s_data_i, word_q[23:8]};
                    if (bcnt_q == 2'd3) begin
                        // Port registers hold the word so addr/data stay stable after the pulse.
                        if (tgt_data_q) begin
                            daddr_d = addr_q;
                            ddata_d = w_word;
                        end else begin
                            iaddr_d = addr_q;
                            idata_d = w_word;
                        end
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + 1'b1;
                cnt_d   = cnt_q - 16'd1;
                state_d = (cnt_q == 16'd1) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (w_accept) begin
                    if (s_data_i != csum_q) begin
                        err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            tgt_data_q <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= 16'd0;
            word_q     <= 24'd0;
            bcnt_q     <= 2'd0;
            csum_q     <= 8'h00;
            cpu_rst_q  <= 1'b0;
            err_q      <= 1'b0;
            iaddr_q    <= '0;
            idata_q    <= 32'd0;
            daddr_q    <= '0;
            ddata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            tgt_data_q <= tgt_data_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            bcnt_q     <= bcnt_d;
            csum_q     <= csum_d;
            cpu_rst_q  <= cpu_rst_d;
            err_q      <= err_d;
            iaddr_q    <= iaddr_d;
            idata_q    <= idata_d;
            daddr_q    <= daddr_d;
            ddata_q    <= ddata_d;
        end
    end

    assign s_ready_o              = (state_q != S_WRITE);
    assign busy_o                 = (state_q != S_IDLE);
    assign cpu_reset_o            = cpu_rst_q;
    assign err_o                  = err_q;

    assign instr_mem_init_enable  = (state_q == S_WRITE) && !tgt_data_q;
    assign instr_mem_init_we      = {4{instr_mem_init_enable}};
    assign instr_mem_init_addr    = iaddr_q;
    assign instr_mem_init_data_in = idata_q;

    assign data_mem_init_enable   = (state_q == S_WRITE) && tgt_data_q;
    assign data_mem_init_we       = {4{data_mem_init_enable}};
    assign data_mem_init_addr     = daddr_q;
    assign data_mem_init_data_in  = ddata_q;

endmodule
`default_nettype wire
